// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the sequenced 4-bit ALU (ula_sequenciador_4bits).
//   WIDTH_DEFAULT : default operand/result width
//   OP_*          : 3-bit opcode encodings
//   state_t       : FSM state encoding (IDLE, EXEC, MUL, DONE)
// ---------------------------------------------------------------------------
package ula_pkg;

  localparam int WIDTH_DEFAULT = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/ula_mul_shift_add.sv
// ---------------------------------------------------------------------------
// ula_mul_shift_add
// Iterative shift-add multiplier: one partial product per enabled step.
// The whole module only exists when the ULA_MUL_EN macro is defined.
//   clk     : rising-edge clock
//   reset   : asynchronous, active-low reset
//   load    : capture a/b and clear the accumulator
//   step    : perform one shift-add iteration
//   a, b    : multiplicand / multiplier (WIDTH bits)
//   product : 2*WIDTH-bit accumulator, final after WIDTH steps
// ---------------------------------------------------------------------------
`ifdef ULA_MUL_EN
module ula_mul_shift_add
  import ula_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  // The multiplicand shifts left and the multiplier shifts right each step,
  // so the multiplier LSB always selects whether the current partial
  // product is added.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign product = acc;

endmodule
`endif

// File: rtl/ula_sequenciador_4bits.sv
// ---------------------------------------------------------------------------
// ula_sequenciador_4bits
// Sequenced ALU stage with a start/busy/done handshake. Operands are
// captured on an accepted start, single-cycle ops resolve in EXEC, and
// (when ULA_MUL_EN is defined) MUL runs a WIDTH-step shift-add multiplier.
// Result and flags are registered and change only on the edge that raises
// done, so a downstream register can load on done alone.
// Optional feature macro: ULA_MUL_EN (multiply support; otherwise op 110 is
// reported as illegal).
//   clk     : rising-edge clock
//   reset   : asynchronous, active-low reset
//   start   : request strobe, sampled in IDLE or DONE only
//   op      : 3-bit opcode, sampled with start
//   a, b    : operands, sampled with start
//   busy    : high in EXEC and MUL
//   done    : one-cycle strobe, result/flags valid
//   result  : registered result
//   carry   : carry / borrow / multiply overflow
//   zero    : result == 0
//   ovf     : signed overflow (ADD/SUB)
//   illegal : unsupported opcode
// ---------------------------------------------------------------------------
module ula_sequenciador_4bits
  import ula_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              carry,
  output logic              zero,
  output logic              ovf,
  output logic              illegal
);

  state_t             state;
  state_t             state_next;
  state_t             start_target;
  logic               accept;

  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;

  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     diff_ext;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;
  logic               alu_ill;

  // A request is only taken when the stage is idle or finishing; start
  // during EXEC/MUL is dropped, not queued.
  assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef ULA_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]       mul_cnt;
  logic                mul_load;
  logic                mul_step;
  logic                mul_last;
  logic [2*WIDTH-1:0]  mul_product;

  assign start_target = (op == OP_MUL) ? MUL : EXEC;

  // The multiplier loads straight from the inputs on the accepting edge, so
  // MUL spends WIDTH cycles stepping plus one cycle registering the product.
  assign mul_load = accept && (op == OP_MUL);
  assign mul_last = (mul_cnt == CW'(WIDTH));
  assign mul_step = (state == MUL) && !mul_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_cnt <= '0;
    end else if (mul_load) begin
      mul_cnt <= '0;
    end else if (mul_step) begin
      mul_cnt <= mul_cnt + 1'b1;
    end
  end

  ula_mul_shift_add #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .load    (mul_load),
    .step    (mul_step),
    .a       (a),
    .b       (b),
    .product (mul_product)
  );
`else
  assign start_target = EXEC;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DONE accepts a new start exactly like IDLE so
  // single-cycle ops can stream at one per two cycles.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = start_target;
        end
      end
      EXEC: begin
        state_next = DONE;
      end
      MUL: begin
`ifdef ULA_MUL_EN
        if (mul_last) begin
          state_next = DONE;
        end
`else
        state_next = IDLE;
`endif
      end
      DONE: begin
        state_next = start ? start_target : IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == EXEC) || (state == MUL);
    done = (state == DONE);
  end

  // Operand capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end
  end

  // Single-cycle ALU on the captured operands. MUL never reaches EXEC when
  // multiply is compiled in, so OP_MUL falls into the illegal default here.
  always_comb begin
    sum_ext   = {1'b0, a_q} + {1'b0, b_q};
    diff_ext  = {1'b0, a_q} - {1'b0, b_q};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_ill   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (sum_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
        alu_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                    (diff_ext[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
      default: begin
        alu_ill = 1'b1;
      end
    endcase
  end

  // Result/flag registers; written only on the edge that enters DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result  <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
      illegal <= 1'b0;
    end else if (state == EXEC) begin
      result  <= alu_res;
      carry   <= alu_carry;
      zero    <= (alu_res == '0);
      ovf     <= alu_ovf;
      illegal <= alu_ill;
    end
`ifdef ULA_MUL_EN
    else if ((state == MUL) && mul_last) begin
      result  <= mul_product[WIDTH-1:0];
      carry   <= |mul_product[2*WIDTH-1:WIDTH];
      zero    <= (mul_product[WIDTH-1:0] == '0);
      ovf     <= 1'b0;
      illegal <= 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_ula_sequenciador_4bits.sv
// ---------------------------------------------------------------------------
// tb_ula_sequenciador_4bits
// Scoreboard bench for ula_sequenciador_4bits. Stimulus pushes hand-computed
// expected results (including the cycle done must appear in); a monitor
// pops and compares on every done and checks that outputs hold otherwise.
// Expectations for op 110 follow the ULA_MUL_EN macro.
// ---------------------------------------------------------------------------
module tb_ula_sequenciador_4bits;

  localparam int W = 4;
`ifdef ULA_MUL_EN
  localparam int MUL_LAT = W + 1;
`else
  localparam int MUL_LAT = 1;
`endif

  typedef struct {
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         ovf;
    logic         illegal;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         ovf;
  logic         illegal;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t held;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  ula_sequenciador_4bits #(
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .carry   (carry),
    .zero    (zero),
    .ovf     (ovf),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: compare on done, otherwise outputs must hold their last value.
  initial begin
    held = '{result: '0, carry: 1'b0, zero: 1'b0, ovf: 1'b0, illegal: 1'b0, cyc: 0};
  end

  always @(negedge clk) begin
    if (!reset) begin
      held = '{result: '0, carry: 1'b0, zero: 1'b0, ovf: 1'b0, illegal: 1'b0, cyc: 0};
    end else if (done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("done_cycle", cyc, mon_e.cyc);
        checkOutput("result", {28'd0, result}, {28'd0, mon_e.result});
        checkOutput("flags", {28'd0, carry, zero, ovf, illegal},
                    {28'd0, mon_e.carry, mon_e.zero, mon_e.ovf, mon_e.illegal});
        held = mon_e;
      end
    end else begin
      checkOutput("hold", {24'd0, result, carry, zero, ovf, illegal},
                  {24'd0, held.result, held.carry, held.zero, held.ovf, held.illegal});
      if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL missing_done: got no done expected done at cycle %0d (now %0d)",
                 sb_q[0].cyc, cyc);
        void'(sb_q.pop_front());
      end
    end
  end

  // Called at a falling edge: drive one start cycle and queue its result.
  task automatic applyStimulus(input logic [2:0] o, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic [W-1:0] r,
                               input logic c, input logic z, input logic v,
                               input logic il, input int lat);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    e.result  = r;
    e.carry   = c;
    e.zero    = z;
    e.ovf     = v;
    e.illegal = il;
    e.cyc     = cyc + 1 + lat;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic runOp(input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] r,
                       input logic c, input logic z, input logic v,
                       input logic il);
    applyStimulus(o, x, y, r, c, z, v, il, 1);
    waitDrain();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int bc;

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {22'd0, busy, done, result, carry, zero, ovf, illegal}, 32'd0);
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("idle_outputs", {22'd0, busy, done, result, carry, zero, ovf, illegal}, 32'd0);
    end

    $display("[TB] single-cycle ops");
    runOp(3'b000, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0);
    runOp(3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
    runOp(3'b001, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b0);
    runOp(3'b010, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    runOp(3'b011, 4'b1100, 4'b1010, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0);
    runOp(3'b101, 4'b0101, 4'b1111, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
    runOp(3'b111, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
    runOp(3'b000, 4'b0010, 4'b0011, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] back-to-back SUB then XOR");
    applyStimulus(3'b001, 4'b0011, 4'b0101, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("b2b_done_seen", {31'd0, done}, 32'd1);
    applyStimulus(3'b100, 4'b1010, 4'b1010, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    waitDrain();

    $display("[TB] multiply");
`ifdef ULA_MUL_EN
    applyStimulus(3'b110, 4'b0110, 4'b0011, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, MUL_LAT);
`else
    applyStimulus(3'b110, 4'b0110, 4'b0011, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, MUL_LAT);
`endif
    bc = 0;
    n = 0;
    while (!done && n < 20) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    checkOutput("mul_busy_cycles", bc, MUL_LAT);
    waitDrain();

    $display("[TB] start ignored while busy");
`ifdef ULA_MUL_EN
    applyStimulus(3'b110, 4'b0011, 4'b0101, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, MUL_LAT);
`else
    applyStimulus(3'b110, 4'b0011, 4'b0101, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, MUL_LAT);
`endif
    start = 1'b1;
    op    = 3'b000;
    a     = 4'b0001;
    b     = 4'b0001;
    @(negedge clk);
    start = 1'b0;
    waitDrain();
    repeat (4) @(negedge clk);

    $display("[TB] reset abort");
`ifdef ULA_MUL_EN
    start = 1'b1;
    op    = 3'b110;
    a     = 4'b0110;
    b     = 4'b0011;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
`else
    start = 1'b1;
    op    = 3'b000;
    a     = 4'b0001;
    b     = 4'b0001;
    @(negedge clk);
    start = 1'b0;
`endif
    checkOutput("busy_before_abort", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("abort_outputs", {22'd0, busy, done, result, carry, zero, ovf, illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("post_abort_idle", {30'd0, busy, done}, 32'd0);
    end
    runOp(3'b000, 4'b0001, 4'b0001, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);

    checkOutput("scoreboard_empty", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
